// File: rtl/timer_unit.sv
// rtl/timer_unit.sv - programmable-tick up/down timer with pause, load, wrap/saturate and expiry
//
// Purpose:
//   Divides clk by TICK_DIV into ticks. The time count steps by one on each tick,
//   either up (wrapping or saturating at max) or down (stopping at zero). The
//   state (IDLE/RUN/PAUSE/DONE) and the pulse outputs are all registered.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   enter RUN from IDLE or PAUSE (level-sampled)
//   pause     in   RUN -> PAUSE, prescaler phase preserved (level-sampled)
//   clear     in   zero time and prescaler, go IDLE (highest priority)
//   load      in   time <= load_val, prescaler zeroed, go IDLE
//   load_val  in   [WIDTH] value applied on load
//   mode      in   0 = count up, 1 = count down (sampled at tick only)
//   wrap_en   in   up mode: 1 = wrap at max, 0 = saturate and finish (sampled at tick only)
//   time_out  out  [WIDTH] current count
//   tick      out  one-cycle pulse for each tick evaluation
//   running   out  state is RUN
//   done      out  state is DONE
//   wrapped   out  one-cycle pulse on an up-count wrap from max to 0

module timer_unit #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] time_out,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             wrapped
);

  localparam int unsigned     PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] time_q, time_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tick_q, tick_d;
  logic             wrapped_q, wrapped_d;
  logic             running_q, done_q;

  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    ps_d      = ps_q;
    tick_d    = 1'b0;
    wrapped_d = 1'b0;

    if (clear) begin
      time_d  = '0;
      ps_d    = '0;
      state_d = S_IDLE;
    end else if (load) begin
      time_d  = load_val;
      ps_d    = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          ps_d = '0;
          // pause outranks start, so asserting both keeps the timer idle
          if (!pause && start) state_d = S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            // freeze with the prescaler phase intact; a tick due now is deferred
            state_d = S_PAUSE;
          end else if (ps_q == PS_LAST) begin
            ps_d   = '0;
            tick_d = 1'b1;
            if (!mode) begin
              if (time_q != T_MAX) begin
                time_d = time_q + WIDTH'(1);
              end else if (wrap_en) begin
                time_d    = '0;
                wrapped_d = 1'b1;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              if (time_q > WIDTH'(1)) begin
                time_d = time_q - WIDTH'(1);
              end else begin
                // reaching or sitting at zero ends the countdown without underflow
                time_d  = '0;
                state_d = S_DONE;
              end
            end
          end else begin
            ps_d = ps_q + PS_W'(1);
          end
        end
        S_PAUSE: begin
          if (!pause && start) state_d = S_RUN;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      time_q    <= '0;
      ps_q      <= '0;
      tick_q    <= 1'b0;
      wrapped_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      ps_q      <= ps_d;
      tick_q    <= tick_d;
      wrapped_q <= wrapped_d;
      // decoded from the next state so the flags move on the same edge as the state
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign time_out = time_q;
  assign tick     = tick_q;
  assign running  = running_q;
  assign done     = done_q;
  assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_timer_unit.sv
// tb/tb_timer_unit.sv - self-checking bench for timer_unit with behavioural model

module tb_timer_unit;

  localparam int TD   = 4;
  localparam int W    = 4;
  localparam int MAXV = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, pause, clear, load, mode, wrap_en;
  logic [W-1:0] load_val;
  logic [W-1:0] time_out;
  logic         tick, running, done, wrapped;

  int n_checks = 0;
  int n_errors = 0;

  timer_unit #(.TICK_DIV(TD), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .wrap_en  (wrap_en),
    .time_out (time_out),
    .tick     (tick),
    .running  (running),
    .done     (done),
    .wrapped  (wrapped)
  );

  always #5 clk = ~clk;

  // Behavioural model: activity 0=idle 1=counting 2=frozen 3=expired
  int m_act  = 0;
  int m_time = 0;
  int m_ps   = 0;
  int m_tick = 0;
  int m_wrap = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 0; m_time = 0; m_ps = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_tick = 0;
      m_wrap = 0;
      if (clear) begin
        m_time = 0; m_ps = 0; m_act = 0;
      end else if (load) begin
        m_time = int'(load_val); m_ps = 0; m_act = 0;
      end else if (m_act == 1 && pause) begin
        m_act = 2;
      end else if ((m_act == 0 || m_act == 2) && start && !pause) begin
        m_act = 1;
      end else if (m_act == 1) begin
        if (m_ps == TD - 1) begin
          m_ps   = 0;
          m_tick = 1;
          if (!mode) begin
            if (m_time < MAXV) m_time = m_time + 1;
            else if (wrap_en) begin m_time = 0; m_wrap = 1; end
            else m_act = 3;
          end else begin
            m_time = (m_time > 0) ? m_time - 1 : 0;
            if (m_time == 0) m_act = 3;
          end
        end else begin
          m_ps = m_ps + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("cmp_time",    int'(time_out), m_time);
    chk("cmp_tick",    int'(tick),     m_tick);
    chk("cmp_wrapped", int'(wrapped),  m_wrap);
    chk("cmp_running", int'(running),  (m_act == 1) ? 1 : 0);
    chk("cmp_done",    int'(done),     (m_act == 3) ? 1 : 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int ticks;

  initial begin
    rst = 1'b0; start = 0; pause = 0; clear = 0; load = 0; mode = 0; wrap_en = 0;
    load_val = '0;
    repeat (3) cyc();
    chk("rst_time", int'(time_out), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrapped", int'(wrapped), 0);
    rst = 1'b1;
    cyc();
    chk("idle_running", int'(running), 0);

    // up count: ticks at edges 4, 8, 12 after start
    start = 1; cyc(); start = 0;
    chk("start_running", int'(running), 1);
    for (int t = 1; t <= 3; t++) begin
      repeat (3) cyc();
      chk("pre_tick", int'(tick), 0);
      cyc();
      chk("up_tick", int'(tick), 1);
      chk("up_time", int'(time_out), t);
    end
    chk("model_up", m_time, 3);

    // wrap at max
    load_val = 4'd15; load = 1; cyc(); load = 0;
    chk("load15", int'(time_out), 15);
    chk("load_idle", int'(running), 0);
    wrap_en = 1; start = 1; cyc(); start = 0;
    repeat (4) cyc();
    chk("wrap_time", int'(time_out), 0);
    chk("wrap_pulse", int'(wrapped), 1);
    chk("wrap_running", int'(running), 1);
    cyc();
    chk("wrap_pulse_end", int'(wrapped), 0);

    // saturate at max
    load = 1; cyc(); load = 0; wrap_en = 0;
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    chk("sat_time", int'(time_out), 15);
    chk("sat_done", int'(done), 1);
    chk("sat_running", int'(running), 0);
    chk("sat_wrapped", int'(wrapped), 0);
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    chk("done_sticky", int'(done), 1);
    chk("done_no_run", int'(running), 0);
    chk("done_time", int'(time_out), 15);

    // countdown from 3
    load_val = 4'd3; load = 1; cyc(); load = 0;
    mode = 1; start = 1; cyc(); start = 0;
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (tick) begin
        ticks++;
        chk("down_time", int'(time_out), 3 - ticks);
        if (ticks == 3) chk("down_done", int'(done), 1);
        else chk("down_running", int'(running), 1);
      end
    end
    chk("down_ticks", ticks, 3);
    chk("model_down", m_act, 3);

    // pause with prescaler at 2, resume continues the phase
    mode = 0; clear = 1; cyc(); clear = 0;
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    chk("p_tick", int'(tick), 1);
    chk("p_time", int'(time_out), 1);
    repeat (2) cyc();
    pause = 1; cyc();
    chk("p_paused", int'(running), 0);
    repeat (10) begin
      cyc();
      chk("p_hold_time", int'(time_out), 1);
      chk("p_hold_tick", int'(tick), 0);
    end
    pause = 0; start = 1; cyc(); start = 0;
    chk("p_resumed", int'(running), 1);
    cyc();
    chk("p_resume_notick", int'(tick), 0);
    cyc();
    chk("p_resume_tick", int'(tick), 1);
    chk("p_resume_time", int'(time_out), 2);

    // clear and load on the cycle a tick is due
    repeat (3) cyc();
    clear = 1; load = 1; load_val = 4'd7; cyc();
    chk("cl_time", int'(time_out), 0);
    chk("cl_tick", int'(tick), 0);
    chk("cl_running", int'(running), 0);
    clear = 0; load_val = 4'd9; cyc(); load = 0;
    chk("ld_time", int'(time_out), 9);
    chk("ld_tick", int'(tick), 0);
    chk("model_ld", m_time, 9);

    // asynchronous reset mid-count
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    chk("pre_rst_time", int'(time_out), 10);
    @(posedge clk); #2 rst = 0; #1;
    chk("arst_time", int'(time_out), 0);
    chk("arst_running", int'(running), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_wrapped", int'(wrapped), 0);
    @(posedge clk); #1 rst = 1;
    repeat (8) cyc();
    chk("post_rst_time", int'(time_out), 0);
    chk("post_rst_running", int'(running), 0);

    // randomized phase, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      clear = ($urandom % 60) == 0;
      load  = ($urandom % 30) == 0;
      pause = ($urandom % 12) == 0;
      start = ($urandom % 5) == 0;
      if (($urandom % 40) == 0) mode = ~mode;
      if (($urandom % 40) == 0) wrap_en = ~wrap_en;
      case ($urandom % 6)
        0: load_val = 4'd0;
        1: load_val = 4'd1;
        2: load_val = 4'd14;
        3: load_val = 4'd15;
        default: load_val = W'($urandom);
      endcase
      cyc();
    end
    clear = 0; load = 0; pause = 0; start = 0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
